// File: rtl/countdown_timer_chain_pkg.sv
// Shared definitions for the countdown timer chain: FSM encoding, default
// mm:ss moduli, and the load-saturation rule applied to each digit.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  // digit0=10, digit1=6, digit2=10, digit3=6 -> max 59:59
  localparam logic [15:0] DEF_MODULI = 16'h6A6A;

  function automatic int sat_load(input int v, input int m);
    return (v >= m) ? (m - 1) : v;
  endfunction

endpackage

// File: rtl/countdown_timer_chain_if.sv
// Control/data bundle between keypad/timebase logic and the timer chain.
interface countdown_timer_chain_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
);
  logic                          tick;
  logic                          loadn;
  logic                          start;
  logic                          stop;
  logic [NUM_DIGITS*DIGIT_W-1:0] data_in;
  logic [NUM_DIGITS*DIGIT_W-1:0] data_out;
  logic                          zero;
  logic                          running;
  logic                          done;
  logic [1:0]                    state;

  modport slave (
    input  tick, loadn, start, stop, data_in,
    output data_out, zero, running, done, state
  );

  modport master (
    output tick, loadn, start, stop, data_in,
    input  data_out, zero, running, done, state
  );
endinterface

// File: rtl/countdown_timer_chain_digit.sv
// Single modulo-MOD down-counting digit; borrows ripple to the next digit
// only when this digit is at 0 and is itself being decremented.
module counter_digit_mod #(
  parameter int DIGIT_W = 4,
  parameter int MOD     = 10
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               borrow_in,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] value,
  output logic               is_zero,
  output logic               borrow_out
);

  logic [DIGIT_W-1:0] r_val;

  always_ff @(posedge clock or posedge clear) begin
    if (clear)          r_val <= '0;
    else if (load)      r_val <= load_val;
    else if (borrow_in) r_val <= is_zero ? DIGIT_W'(MOD - 1) : r_val - DIGIT_W'(1);
  end

  assign value      = r_val;
  assign is_zero    = (r_val == '0);
  assign borrow_out = borrow_in & is_zero;

endmodule

// File: rtl/countdown_timer_chain.sv
// Multi-digit countdown timer: cascaded modulo digits under a small
// IDLE/RUN/PAUSED/DONE run-control FSM.
module countdown_timer_chain
  import timer_pkg::*;
#(
  parameter int                            NUM_DIGITS = 4,
  parameter int                            DIGIT_W    = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] MODULI     = DEF_MODULI
) (
  input  logic                  clock,
  input  logic                  clear,
  countdown_timer_chain_if.slave bus
);

  state_t r_state, w_nxt;
  logic   r_done, w_done_nxt;
  logic   w_ld, w_clr, w_dec, w_zero, w_one;

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_val, w_ld_val;
  logic [NUM_DIGITS-1:0]              w_is_zero;
  logic [NUM_DIGITS:0]                w_borrow;

  assign w_borrow[0] = w_dec;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    localparam int FLD   = int'(MODULI[gi*DIGIT_W +: DIGIT_W]);
    // A zero field encodes the full 2^DIGIT_W modulus.
    localparam int MOD_I = (FLD == 0) ? (1 << DIGIT_W) : FLD;

    assign w_ld_val[gi] = w_clr ? '0
                        : DIGIT_W'(sat_load(int'(bus.data_in[gi*DIGIT_W +: DIGIT_W]), MOD_I));

    counter_digit_mod #(.DIGIT_W(DIGIT_W), .MOD(MOD_I)) u_digit (
      .clock      (clock),
      .clear      (clear),
      .borrow_in  (w_borrow[gi]),
      .load       (w_ld | w_clr),
      .load_val   (w_ld_val[gi]),
      .value      (w_val[gi]),
      .is_zero    (w_is_zero[gi]),
      .borrow_out (w_borrow[gi+1])
    );
  end

  assign w_zero = &w_is_zero;
  assign w_one  = (w_val[0] == DIGIT_W'(1)) && ((w_is_zero | NUM_DIGITS'(1)) == '1);

  // Priority: loadn > stop > start > tick; loadn in RUN is treated as absent.
  always_comb begin
    w_nxt      = r_state;
    w_ld       = 1'b0;
    w_clr      = 1'b0;
    w_dec      = 1'b0;
    w_done_nxt = 1'b0;
    if (!bus.loadn && r_state != ST_RUN) begin
      w_ld  = 1'b1;
      w_nxt = ST_IDLE;
    end else if (bus.stop) begin
      case (r_state)
        ST_RUN:    w_nxt = ST_PAUSED;
        ST_PAUSED: begin w_clr = 1'b1; w_nxt = ST_IDLE; end
        ST_DONE:   w_nxt = ST_IDLE;
        default:   w_nxt = r_state;
      endcase
    end else if (bus.start) begin
      if ((r_state == ST_IDLE || r_state == ST_PAUSED) && !w_zero) w_nxt = ST_RUN;
    end else if (bus.tick && r_state == ST_RUN) begin
      w_dec = 1'b1;
      if (w_one) begin
        w_nxt      = ST_DONE;
        w_done_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.data_out = w_val;
  assign bus.zero     = w_zero;
  assign bus.running  = (r_state == ST_RUN);
  assign bus.done     = r_done;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_countdown_timer_chain.sv
// Directed bench for countdown_timer_chain in its default 59:59 configuration.
module tb_countdown_timer_chain;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   vecs  = 0;
  int   errs  = 0;

  countdown_timer_chain_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus ();

  countdown_timer_chain #(.NUM_DIGITS(4), .DIGIT_W(4), .MODULI(16'h6A6A)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_load(input logic [15:0] d);
    bus.data_in = d; bus.loadn = 1'b0; cyc(); bus.loadn = 1'b1;
  endtask

  task automatic do_start();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
  endtask

  task automatic do_tick(input int n = 1);
    repeat (n) begin bus.tick = 1'b1; cyc(); bus.tick = 1'b0; end
  endtask

  // Observed tuple: {state, done, data_out}
  task automatic test_reset();
    #1;
    vecs++;
    if ({bus.state, bus.done, bus.data_out} !== {2'b00, 1'b0, 16'h0000}) begin
      errs++; $display("FAIL reset: got st=%0d done=%0b out=%h want st=0 done=0 out=0000", bus.state, bus.done, bus.data_out);
    end
    clear = 1'b0;
    cyc();
  endtask

  task automatic test_reset_midrun();
    do_load(16'h0105); do_start(); do_tick(3);
    vecs++;
    if ({bus.state, bus.data_out} !== {2'b01, 16'h0102}) begin
      errs++; $display("FAIL midrun_pre: got st=%0d out=%h want st=1 out=0102", bus.state, bus.data_out);
    end
    #2 clear = 1'b1;
    #1;
    vecs++;
    if ({bus.state, bus.done, bus.data_out, bus.running} !== {2'b00, 1'b0, 16'h0000, 1'b0}) begin
      errs++; $display("FAIL midrun_clear: got st=%0d done=%0b out=%h want st=0 done=0 out=0000", bus.state, bus.done, bus.data_out);
    end
    #1 clear = 1'b0;
    cyc();
  endtask

  task automatic test_borrow();
    do_load(16'h0100); do_start(); do_tick();
    vecs++;
    if (bus.data_out !== 16'h0059) begin
      errs++; $display("FAIL borrow_1: got %h want 0059", bus.data_out);
    end
    do_tick();
    vecs++;
    if (bus.data_out !== 16'h0058) begin
      errs++; $display("FAIL borrow_2: got %h want 0058", bus.data_out);
    end
    do_stop(); do_stop();
  endtask

  task automatic test_cascade();
    do_load(16'h1000); do_start(); do_tick();
    vecs++;
    if ({bus.state, bus.data_out} !== {2'b01, 16'h0959}) begin
      errs++; $display("FAIL cascade: got st=%0d out=%h want st=1 out=0959", bus.state, bus.data_out);
    end
    do_stop(); do_stop();
  endtask

  task automatic test_sat_load();
    do_load(16'hFFFF);
    vecs++;
    if ({bus.state, bus.zero, bus.data_out} !== {2'b00, 1'b0, 16'h5959}) begin
      errs++; $display("FAIL sat_ffff: got st=%0d zero=%0b out=%h want st=0 zero=0 out=5959", bus.state, bus.zero, bus.data_out);
    end
    do_load(16'h7A3C);
    vecs++;
    if (bus.data_out !== 16'h5939) begin
      errs++; $display("FAIL sat_mixed: got %h want 5939", bus.data_out);
    end
  endtask

  task automatic test_completion();
    do_load(16'h0002); do_start(); do_tick();
    vecs++;
    if ({bus.state, bus.done, bus.data_out} !== {2'b01, 1'b0, 16'h0001}) begin
      errs++; $display("FAIL comp_one: got st=%0d done=%0b out=%h want st=1 done=0 out=0001", bus.state, bus.done, bus.data_out);
    end
    do_tick();
    vecs++;
    if ({bus.state, bus.done, bus.data_out, bus.zero, bus.running} !== {2'b11, 1'b1, 16'h0000, 1'b1, 1'b0}) begin
      errs++; $display("FAIL comp_done: got st=%0d done=%0b out=%h zero=%0b run=%0b want st=3 done=1 out=0000 zero=1 run=0",
                       bus.state, bus.done, bus.data_out, bus.zero, bus.running);
    end
    cyc();
    vecs++;
    if ({bus.state, bus.done} !== {2'b11, 1'b0}) begin
      errs++; $display("FAIL comp_pulse: got st=%0d done=%0b want st=3 done=0", bus.state, bus.done);
    end
    do_tick(2); do_start();
    vecs++;
    if ({bus.state, bus.done, bus.data_out} !== {2'b11, 1'b0, 16'h0000}) begin
      errs++; $display("FAIL comp_hold: got st=%0d done=%0b out=%h want st=3 done=0 out=0000", bus.state, bus.done, bus.data_out);
    end
    do_stop();
    vecs++;
    if ({bus.state, bus.data_out} !== {2'b00, 16'h0000}) begin
      errs++; $display("FAIL comp_stop: got st=%0d out=%h want st=0 out=0000", bus.state, bus.data_out);
    end
  endtask

  task automatic test_priority();
    do_load(16'h0030);
    bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
    vecs++;
    if ({bus.state, bus.data_out} !== {2'b00, 16'h0030}) begin
      errs++; $display("FAIL tick_idle: got st=%0d out=%h want st=0 out=0030", bus.state, bus.data_out);
    end
    do_start(); do_tick();
    vecs++;
    if ({bus.state, bus.data_out} !== {2'b01, 16'h0029}) begin
      errs++; $display("FAIL prio_run: got st=%0d out=%h want st=1 out=0029", bus.state, bus.data_out);
    end
    bus.tick = 1'b1; bus.stop = 1'b1; cyc(); bus.tick = 1'b0; bus.stop = 1'b0;
    vecs++;
    if ({bus.state, bus.data_out} !== {2'b10, 16'h0029}) begin
      errs++; $display("FAIL tick_stop: got st=%0d out=%h want st=2 out=0029", bus.state, bus.data_out);
    end
    do_tick();
    vecs++;
    if ({bus.state, bus.data_out} !== {2'b10, 16'h0029}) begin
      errs++; $display("FAIL tick_paused: got st=%0d out=%h want st=2 out=0029", bus.state, bus.data_out);
    end
    do_start(); do_load(16'h1234);
    vecs++;
    if ({bus.state, bus.data_out} !== {2'b01, 16'h0029}) begin
      errs++; $display("FAIL load_in_run: got st=%0d out=%h want st=1 out=0029", bus.state, bus.data_out);
    end
    do_stop(); do_stop();
    vecs++;
    if ({bus.state, bus.data_out} !== {2'b00, 16'h0000}) begin
      errs++; $display("FAIL stop_paused: got st=%0d out=%h want st=0 out=0000", bus.state, bus.data_out);
    end
    do_start(); cyc();
    vecs++;
    if ({bus.state, bus.done, bus.running} !== {2'b00, 1'b0, 1'b0}) begin
      errs++; $display("FAIL start_zero: got st=%0d done=%0b run=%0b want st=0 done=0 run=0", bus.state, bus.done, bus.running);
    end
    bus.start = 1'b1; do_load(16'h0007); bus.start = 1'b0;
    vecs++;
    if ({bus.state, bus.data_out} !== {2'b00, 16'h0007}) begin
      errs++; $display("FAIL load_over_start: got st=%0d out=%h want st=0 out=0007", bus.state, bus.data_out);
    end
  endtask

  initial begin
    bus.tick = 1'b0; bus.loadn = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
    bus.data_in = '0;
    test_reset();
    test_reset_midrun();
    test_borrow();
    test_cascade();
    test_sat_load();
    test_completion();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
